mem_stage: RTL and testbench

- Memory-access pipeline stage: the consumer end of the execute-to-memory interface.
- Accepts a result or address, destination register and access attributes from execute.
- Performs loads and stores on a single-beat req/ack data-memory port; back-pressures execute with MEMEX_stall while an access is outstanding.
- Supplies a forwarding value back to execute; hands the completed write-back to the next stage.

---
 rtl/mem_stage.sv | 117 +++++++++++
 tb/tb_mem_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; single-beat loads/stores, forwarding and write-back hand-off.
module mem_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            EXMEM_ready,
  input  logic [XLEN-1:0] exmm_aluresult,
  input  logic [REGW-1:0] dest_reg,
  input  logic            load,
  input  logic            store,
  input  logic [XLEN-1:0] store_data,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  output logic            MEMEX_stall,
  output logic [REGW-1:0] MEMEX_rd,
  output logic [XLEN-1:0] MEMEX_rdval,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            MEMWB_ready,
  output logic [REGW-1:0] MEMWB_rd,
  output logic [XLEN-1:0] MEMWB_rdval,
  output logic            misalign_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic accept, is_mem, is_st, misal;
  logic [2:0] off, amask;
  logic [7:0] bmask;
  logic [REGW-1:0] h_rd;
  logic [2:0] h_off;
  logic [1:0] h_size;
  logic h_uns, h_st;
  logic [XLEN-1:0] h_res, sh, ld_val;
  always_comb begin
    accept = EXMEM_ready && !MEMEX_stall;
    is_mem = load || store;
    is_st = store && !load;
    off = exmm_aluresult[2:0];
    amask = mem_size == 2'd0 ? 3'd0 : mem_size == 2'd1 ? 3'd1 : mem_size == 2'd2 ? 3'd3 : 3'd7;
    bmask = mem_size == 2'd0 ? 8'h01 : mem_size == 2'd1 ? 8'h03 : mem_size == 2'd2 ? 8'h0F : 8'hFF;
    misal = (off & amask) != 3'd0;
    sh = dmem_rdata >> {h_off, 3'b000};
    ld_val = h_size == 2'd0 ? {{(XLEN-8){~h_uns & sh[7]}}, sh[7:0]} :
             h_size == 2'd1 ? {{(XLEN-16){~h_uns & sh[15]}}, sh[15:0]} :
             h_size == 2'd2 ? {{(XLEN-32){~h_uns & sh[31]}}, sh[31:0]} : sh;
  end
  // Forwarding is only meaningful during the write-back pulse; stores and faults carry rd=0.
  assign MEMEX_rd = MEMWB_ready ? MEMWB_rd : '0;
  assign MEMEX_rdval = MEMWB_rdval;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      MEMEX_stall <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      MEMWB_ready <= 1'b0;
      MEMWB_rd <= '0;
      MEMWB_rdval <= '0;
      misalign_err <= 1'b0;
      h_rd <= '0;
      h_off <= '0;
      h_size <= '0;
      h_uns <= 1'b0;
      h_st <= 1'b0;
      h_res <= '0;
    end else begin
      MEMWB_ready <= 1'b0;
      misalign_err <= 1'b0;
      if (state == BUSY) begin
        if (dmem_ack) begin
          state <= IDLE;
          MEMEX_stall <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we <= 1'b0;
          MEMWB_ready <= 1'b1;
          MEMWB_rd <= h_st ? '0 : h_rd;
          MEMWB_rdval <= h_st ? h_res : ld_val;
        end
      end else if (accept) begin
        if (!is_mem) begin
          MEMWB_ready <= 1'b1;
          MEMWB_rd <= dest_reg;
          MEMWB_rdval <= exmm_aluresult;
        end else if (misal) begin
          misalign_err <= 1'b1;
          MEMWB_ready <= 1'b1;
          MEMWB_rd <= '0;
          MEMWB_rdval <= exmm_aluresult;
        end else begin
          state <= BUSY;
          MEMEX_stall <= 1'b1;
          dmem_req <= 1'b1;
          dmem_we <= is_st;
          dmem_addr <= {exmm_aluresult[XLEN-1:3], 3'b000};
          dmem_wdata <= is_st ? store_data << {off, 3'b000} : '0;
          dmem_wstrb <= is_st ? bmask << off : 8'h00;
          h_rd <= dest_reg;
          h_off <= off;
          h_size <= mem_size;
          h_uns <= mem_unsigned;
          h_st <= is_st;
          h_res <= exmm_aluresult;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with directed load/store/ALU vectors.
module tb_mem_stage;
  logic clk, reset, EXMEM_ready, load, store, mem_unsigned, dmem_ack;
  logic [63:0] exmm_aluresult, store_data, dmem_rdata;
  logic [5:0] dest_reg;
  logic [1:0] mem_size;
  logic MEMEX_stall, dmem_req, dmem_we, MEMWB_ready, misalign_err;
  logic [5:0] MEMEX_rd, MEMWB_rd;
  logic [63:0] MEMEX_rdval, dmem_addr, dmem_wdata, MEMWB_rdval;
  logic [7:0] dmem_wstrb;
  typedef struct {logic [5:0] rd; logic [63:0] val; logic mis; logic cv;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .EXMEM_ready(EXMEM_ready), .exmm_aluresult(exmm_aluresult),
    .dest_reg(dest_reg), .load(load), .store(store), .store_data(store_data),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .MEMEX_stall(MEMEX_stall),
    .MEMEX_rd(MEMEX_rd), .MEMEX_rdval(MEMEX_rdval), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .MEMWB_ready(MEMWB_ready),
    .MEMWB_rd(MEMWB_rd), .MEMWB_rdval(MEMWB_rdval), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && MEMWB_ready === 1'b1) begin
      if (q.size() == 0) chk("unexpected_wb", 64'(MEMWB_rd), 64'h3F);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_rd", 64'(MEMWB_rd), 64'(e.rd));
        chk("fwd_rd", 64'(MEMEX_rd), 64'(e.rd));
        chk("wb_misalign", 64'(misalign_err), 64'(e.mis));
        if (e.cv) begin
          chk("wb_rdval", MEMWB_rdval, e.val);
          chk("fwd_rdval", MEMEX_rdval, e.val);
        end
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [63:0] a, input logic [1:0] sz,
                       input logic uns, input logic [63:0] sd, input logic [5:0] rd);
    load = ld; store = st; exmm_aluresult = a; mem_size = sz; mem_unsigned = uns;
    store_data = sd; dest_reg = rd; EXMEM_ready = 1'b1;
    @(posedge clk); #1;
    EXMEM_ready = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  task automatic serve(input int waits, input logic [63:0] rdata);
    int n = 0;
    dmem_rdata = rdata;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      if (MEMEX_stall) n++;
      if (i == waits) dmem_ack = 1'b1;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stall_len", 64'(n), 64'(waits + 1));
    chk("stall_clear", 64'(MEMEX_stall), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; EXMEM_ready = 1'b0; load = 1'b0; store = 1'b0; mem_unsigned = 1'b0;
    dmem_ack = 1'b0; exmm_aluresult = '0; store_data = '0; dmem_rdata = '0;
    dest_reg = '0; mem_size = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(MEMEX_stall), 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_we", 64'(dmem_we), 64'd0);
    chk("rst_wb_ready", 64'(MEMWB_ready), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    chk("rst_rd", 64'({MEMEX_rd, MEMWB_rd}), 64'd0);
    chk("rst_vals", MEMEX_rdval | MEMWB_rdval | dmem_addr | dmem_wdata | 64'(dmem_wstrb), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // ALU pass-through
    q.push_back('{rd: 6'd5, val: 64'h1234, mis: 1'b0, cv: 1'b1});
    drive(1'b0, 1'b0, 64'h1234, 2'd0, 1'b0, 64'h0, 6'd5);
    @(negedge clk);
    chk("alu_req", 64'(dmem_req), 64'd0);
    chk("alu_ready", 64'(MEMWB_ready), 64'd1);
    @(negedge clk);
    chk("alu_pulse_once", 64'(MEMWB_ready), 64'd0);

    // signed byte load, three wait cycles
    q.push_back('{rd: 6'd7, val: 64'hFFFFFFFF_FFFFFF80, mis: 1'b0, cv: 1'b1});
    drive(1'b1, 1'b0, 64'h1003, 2'd0, 1'b0, 64'h0, 6'd7);
    @(negedge clk);
    chk("lb_addr", dmem_addr, 64'h1000);
    chk("lb_req", 64'(dmem_req), 64'd1);
    chk("lb_we", 64'(dmem_we), 64'd0);
    chk("lb_fwd_busy", 64'(MEMEX_rd), 64'd0);
    serve(3, 64'h00000000_80000000);

    // unsigned byte load
    q.push_back('{rd: 6'd8, val: 64'h80, mis: 1'b0, cv: 1'b1});
    drive(1'b1, 1'b0, 64'h1003, 2'd0, 1'b1, 64'h0, 6'd8);
    serve(3, 64'h00000000_80000000);

    // signed word load from upper half
    q.push_back('{rd: 6'd11, val: 64'hFFFFFFFF_87654321, mis: 1'b0, cv: 1'b1});
    drive(1'b1, 1'b0, 64'h5004, 2'd2, 1'b0, 64'h0, 6'd11);
    serve(1, 64'h87654321_00000000);

    // halfword store
    q.push_back('{rd: 6'd0, val: 64'h0, mis: 1'b0, cv: 1'b0});
    drive(1'b0, 1'b1, 64'h2006, 2'd1, 1'b0, 64'hBEEF, 6'd12);
    @(negedge clk);
    chk("sh_we", 64'(dmem_we), 64'd1);
    chk("sh_strb", 64'(dmem_wstrb), 64'hC0);
    chk("sh_wdata", dmem_wdata, 64'hBEEF0000_00000000);
    chk("sh_addr", dmem_addr, 64'h2000);
    serve(1, 64'h0);

    // misaligned word load
    q.push_back('{rd: 6'd0, val: 64'h0, mis: 1'b1, cv: 1'b0});
    drive(1'b1, 1'b0, 64'h3002, 2'd2, 1'b0, 64'h0, 6'd13);
    @(negedge clk);
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_stall", 64'(MEMEX_stall), 64'd0);
    @(negedge clk);
    chk("mis_pulse_once", 64'(misalign_err), 64'd0);
    chk("mis_req2", 64'(dmem_req), 64'd0);

    // back-to-back: doubleword load with immediate ack, ALU op held behind it
    q.push_back('{rd: 6'd9, val: 64'h11223344_55667788, mis: 1'b0, cv: 1'b1});
    q.push_back('{rd: 6'd10, val: 64'hABCD, mis: 1'b0, cv: 1'b1});
    drive(1'b1, 1'b0, 64'h4008, 2'd3, 1'b1, 64'h0, 6'd9);
    dmem_rdata = 64'h11223344_55667788; dmem_ack = 1'b1;
    exmm_aluresult = 64'hABCD; dest_reg = 6'd10; EXMEM_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("b2b_stall_fell", 64'(MEMEX_stall), 64'd0);
    @(posedge clk); #1;
    EXMEM_ready = 1'b0;
    chk("b2b_alu_idle", 64'(dmem_req), 64'd0);
    repeat (2) @(negedge clk);
    chk("b2b_drained", 64'(q.size()), 64'd0);

    // reset mid-access aborts the load
    drive(1'b1, 1'b0, 64'h1000, 2'd3, 1'b0, 64'h0, 6'd14);
    @(negedge clk);
    chk("rma_req_busy", 64'(dmem_req), 64'd1);
    #1 reset = 1'b0;
    #1 chk("rma_req_async", 64'(dmem_req), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    dmem_ack = 1'b1;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    chk("rma_no_wb", 64'(MEMWB_ready), 64'd0);
    chk("rma_idle", 64'({MEMEX_stall, dmem_req}), 64'd0);
    chk("rma_queue", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
